// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of bram_port_arbiter: per-requester write/read
// requests with flattened address/data slices, one-hot grants and the
// shared registered read-return channel.
// master: requester lanes (drive requests, receive grants and read data)
// slave : the arbiter
interface bram_port_arbiter_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            wr_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]            wr_gnt;
  logic [NUM_REQ-1:0]            rd_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]            rd_gnt;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_gnt, rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_gnt, rd_gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM (one write port, one asynchronous
// read port) between NUM_REQ requester lanes. Write and read ports are
// arbitrated independently and combinationally; read data is registered
// and returned to the granted lane one cycle after its grant.
// Optional feature macro: BRAM_ARB_WR_BYPASS_EN -- when defined, a read of
// the address being written in the same cycle returns the new data
// (write-first); otherwise it returns the old BRAM contents (read-first).
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REQ    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_port_arbiter_if.slave    bus,
  output logic                  bram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] bram_write_addr_o,
  output logic [DATA_WIDTH-1:0] bram_data_in_o,
  output logic [ADDR_WIDTH-1:0] bram_read_addr_o,
  input  logic [DATA_WIDTH-1:0] bram_data_out_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // First requester at or after ptr, wrapping. Scanning from the far end
  // backwards lets the nearest hit overwrite any later one.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [PTR_W-1:0]   ptr);
    pick_t p;
    int    j;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        p.found = 1'b1;
        p.idx   = PTR_W'(j);
      end
    end
    return p;
  endfunction

  // Pointer position just past the winner, modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  pick_t                 wr_pick, rd_pick;
  logic                  wr_en, rd_en;

  // Pick winners; grants are suppressed while reset is asserted.
  always_comb begin
    wr_pick = rr_pick(bus.wr_req, wr_ptr_q);
    rd_pick = rr_pick(bus.rd_req, rd_ptr_q);
    wr_en   = wr_pick.found && rst_n;
    rd_en   = rd_pick.found && rst_n;
  end

  // One-hot grants and BRAM port muxing of the granted lane's slice.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    bus.wr_gnt        = '0;
    bus.rd_gnt        = '0;
    bram_wr_en_o      = 1'b0;
    bram_write_addr_o = '0;
    bram_data_in_o    = '0;
    bram_read_addr_o  = '0;
    if (wr_en) begin
      bus.wr_gnt[wr_pick.idx] = 1'b1;
      bram_wr_en_o      = 1'b1;
      bram_write_addr_o = bus.wr_addr[int'(wr_pick.idx)*ADDR_WIDTH +: ADDR_WIDTH];
      bram_data_in_o    = bus.wr_data[int'(wr_pick.idx)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (rd_en) begin
      bus.rd_gnt[rd_pick.idx] = 1'b1;
      bram_read_addr_o  = bus.rd_addr[int'(rd_pick.idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Next-state: advance pointers past winners, capture read return.
  always_comb begin
    wr_ptr_d   = wr_en ? ptr_after(wr_pick.idx) : wr_ptr_q;
    rd_ptr_d   = rd_en ? ptr_after(rd_pick.idx) : rd_ptr_q;
    rd_valid_d = bus.rd_gnt;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
`ifdef BRAM_ARB_WR_BYPASS_EN
      if (bram_wr_en_o && (bram_write_addr_o == bram_read_addr_o))
        rd_data_d = bram_data_in_o;
      else
        rd_data_d = bram_data_out_i;
`else
      rd_data_d = bram_data_out_i;
`endif
    end
  end

  // State registers; reset discards any in-flight read return.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; the read-data register is reset, the BRAM is not.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter. A behavioural model (integer
// round-robin pointers, a mirror of the BRAM contents, expected read return)
// is compared against the DUT every negative clock edge; directed scenarios
// add hand-computed literal expectations.
module tb_bram_port_arbiter;
  localparam int DW = 128;
  localparam int AW = 6;
  localparam int NR = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

  logic          bram_wr_en;
  logic [AW-1:0] bram_write_addr;
  logic [DW-1:0] bram_data_in;
  logic [AW-1:0] bram_read_addr;
  logic [DW-1:0] bram_data_out;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .bram_wr_en_o     (bram_wr_en),
    .bram_write_addr_o(bram_write_addr),
    .bram_data_in_o   (bram_data_in),
    .bram_read_addr_o (bram_read_addr),
    .bram_data_out_i  (bram_data_out)
  );

  // BRAM: synchronous write, asynchronous read.
  logic [DW-1:0] bram_mem [0:(1<<AW)-1];
  always @(posedge clk) if (bram_wr_en) bram_mem[bram_write_addr] <= bram_data_in;
  assign bram_data_out = bram_mem[bram_read_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rr_winner(input logic [NR-1:0] req, input int ptr);
    for (int k = 0; k < NR; k++)
      if (req[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    return (i >= 0) ? NR'(1) << i : '0;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [NR*AW-1:0] v, input int i);
    return (i >= 0) ? v[i*AW +: AW] : '0;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [NR*DW-1:0] v, input int i);
    return (i >= 0) ? v[i*DW +: DW] : '0;
  endfunction

  int            m_wp, m_rp;
  logic [NR-1:0] m_valid;
  logic [DW-1:0] m_data;
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  int            exp_w, exp_r;

  assign exp_w = rst_n ? rr_winner(bus.wr_req, m_wp) : -1;
  assign exp_r = rst_n ? rr_winner(bus.rd_req, m_rp) : -1;

  // Value a granted read must return: old contents, or the data being
  // written to that same address when write-first bypass is built in.
  function automatic logic [DW-1:0] read_result(input logic [NR*AW-1:0] ra_v,
                                                input logic [NR*AW-1:0] wa_v,
                                                input logic [NR*DW-1:0] wd_v,
                                                input int w, input int r);
    logic [AW-1:0] ra;
    ra = addr_of(ra_v, r);
`ifdef BRAM_ARB_WR_BYPASS_EN
    if (w >= 0 && addr_of(wa_v, w) == ra) return data_of(wd_v, w);
`endif
    return mem_m[ra];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wp    <= 0;
      m_rp    <= 0;
      m_valid <= '0;
      m_data  <= '0;
    end else begin
      if (exp_w >= 0) begin
        m_wp <= (exp_w + 1) % NR;
        mem_m[addr_of(bus.wr_addr, exp_w)] <= data_of(bus.wr_data, exp_w);
      end
      m_valid <= onehot(exp_r);
      if (exp_r >= 0) begin
        m_rp   <= (exp_r + 1) % NR;
        m_data <= read_result(bus.rd_addr, bus.wr_addr, bus.wr_data, exp_w, exp_r);
      end
    end
  end

  // Compare process: every negative edge, DUT versus model.
  always @(negedge clk) begin
    check("m_wr_gnt",     bus.wr_gnt,      onehot(exp_w));
    check("m_rd_gnt",     bus.rd_gnt,      onehot(exp_r));
    check("m_wr_en",      bram_wr_en,      exp_w >= 0);
    check("m_wr_addr",    bram_write_addr, addr_of(bus.wr_addr, exp_w));
    check("m_data_in",    bram_data_in,    data_of(bus.wr_data, exp_w));
    check("m_rd_addr",    bram_read_addr,  addr_of(bus.rd_addr, exp_r));
    check("m_rd_valid",   bus.rd_valid,    m_valid);
    check("m_rd_data",    bus.rd_data,     m_data);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_addr[i*AW +: AW] = a;
    bus.wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    bus.rd_addr[i*AW +: AW] = a;
  endtask

  task automatic apply_reset();
    bus.wr_req = '0;
    bus.rd_req = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [NR-1:0] fair_seq [8];
  logic [DW-1:0] same_addr_exp;

  initial begin
    fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef BRAM_ARB_WR_BYPASS_EN
    same_addr_exp = DW'(32'h22);
`else
    same_addr_exp = DW'(32'h11);
`endif
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    // Requests present during reset must not be granted.
    bus.wr_req = '1;
    bus.rd_req = '1;
    mid();
    check("rst_wr_gnt",   bus.wr_gnt,   '0);
    check("rst_rd_gnt",   bus.rd_gnt,   '0);
    check("rst_wr_en",    bram_wr_en,   1'b0);
    check("rst_rd_valid", bus.rd_valid, '0);
    check("rst_rd_data",  bus.rd_data,  '0);
    bus.wr_req = '0;
    bus.rd_req = '0;
    tick();
    rst_n = 1'b1;

    // Single write then read-back of address 5.
    set_wr(0, 6'd5, DW'(32'hA5));
    bus.wr_req = 4'b0001;
    mid();
    check("sw_wr_gnt",  bus.wr_gnt,      4'b0001);
    check("sw_wr_en",   bram_wr_en,      1'b1);
    check("sw_wr_addr", bram_write_addr, 6'd5);
    tick();
    bus.wr_req = '0;
    set_rd(0, 6'd5);
    bus.rd_req = 4'b0001;
    mid();
    check("sr_rd_gnt",  bus.rd_gnt,     4'b0001);
    check("sr_rd_addr", bram_read_addr, 6'd5);
    tick();
    bus.rd_req = '0;
    mid();
    check("sr_rd_valid", bus.rd_valid, 4'b0001);
    check("sr_rd_data",  bus.rd_data,  DW'(32'hA5));
    tick();

    // Preload every address with 0x5000 + a*0x101.
    for (int a = 0; a < (1 << AW); a++) begin
      set_wr(0, AW'(a), DW'(32'h5000 + a * 32'h101));
      bus.wr_req = 4'b0001;
      tick();
    end
    bus.wr_req = '0;

    // Fairness with all four write requests held.
    apply_reset();
    for (int i = 0; i < NR; i++) set_wr(i, AW'(40 + i), DW'(32'hF00 + i));
    bus.wr_req = '1;
    for (int c = 0; c < 8; c++) begin
      mid();
      check("fair_wr_gnt", bus.wr_gnt, fair_seq[c]);
      tick();
    end
    bus.wr_req = '0;

    // Reads from requesters 1 and 3 out of reset.
    apply_reset();
    set_rd(1, 6'd7);
    set_rd(3, 6'd12);
    bus.rd_req = 4'b1010;
    mid();
    check("rr_gnt_a",  bus.rd_gnt,     4'b0010);
    check("rr_addr_a", bram_read_addr, 6'd7);
    tick();
    bus.rd_req = 4'b1000;
    mid();
    check("rr_gnt_b",   bus.rd_gnt,     4'b1000);
    check("rr_addr_b",  bram_read_addr, 6'd12);
    check("rr_valid_a", bus.rd_valid,   4'b0010);
    check("rr_data_a",  bus.rd_data,    DW'(32'h5707));
    tick();
    bus.rd_req = '0;
    mid();
    check("rr_valid_b", bus.rd_valid, 4'b1000);
    check("rr_data_b",  bus.rd_data,  DW'(32'h5C0C));
    tick();

    // Same-address read and write on address 9.
    set_wr(0, 6'd9, DW'(32'h11));
    bus.wr_req = 4'b0001;
    tick();
    set_wr(0, 6'd9, DW'(32'h22));
    set_rd(0, 6'd9);
    bus.rd_req = 4'b0001;
    mid();
    check("sa_wr_gnt", bus.wr_gnt, 4'b0001);
    check("sa_rd_gnt", bus.rd_gnt, 4'b0001);
    tick();
    bus.wr_req = '0;
    mid();
    check("sa_rd_data", bus.rd_data, same_addr_exp);
    tick();
    bus.rd_req = '0;
    mid();
    check("sa_after", bus.rd_data, DW'(32'h22));
    tick();

    // Requester 2 alone, then requester 0 joins.
    set_wr(2, 6'd20, DW'(32'h77));
    bus.wr_req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      mid();
      check("solo_wr_gnt", bus.wr_gnt, 4'b0100);
      tick();
    end
    set_wr(0, 6'd21, DW'(32'h78));
    bus.wr_req = 4'b0101;
    mid();
    check("join_wr_gnt", bus.wr_gnt, 4'b0001);
    tick();
    bus.wr_req = 4'b0100;
    mid();
    check("join_wr_gnt2", bus.wr_gnt, 4'b0100);
    tick();
    bus.wr_req = '0;

    // Reset pulsed while a read is granted.
    set_wr(1, 6'd50, DW'(32'h99));
    set_rd(2, 6'd7);
    bus.wr_req = 4'b0010;
    bus.rd_req = 4'b0100;
    mid();
    check("mr_rd_gnt", bus.rd_gnt, 4'b0100);
    check("mr_wr_gnt", bus.wr_gnt, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_wr_gnt_low", bus.wr_gnt,   '0);
    check("mr_rd_gnt_low", bus.rd_gnt,   '0);
    check("mr_wr_en_low",  bram_wr_en,   1'b0);
    check("mr_valid_low",  bus.rd_valid, '0);
    tick();
    check("mr_valid_edge", bus.rd_valid, '0);
    bus.wr_req = '1;
    bus.rd_req = '1;
    rst_n = 1'b1;
    mid();
    check("mr_wr_gnt_post", bus.wr_gnt,   4'b0001);
    check("mr_rd_gnt_post", bus.rd_gnt,   4'b0001);
    check("mr_valid_post",  bus.rd_valid, '0);
    tick();
    bus.wr_req = '0;
    bus.rd_req = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Round-robin arbiter that shares one dual-address BRAM (single write port, single asynchronous read port) between NUM_REQ requesters in the OT accelerator datapath.
- Read and write ports are arbitrated independently each cycle; read data is registered and returned to the granted requester one cycle later.
- Sits between the OT engine lanes and one BRAM instance; drives the BRAM's data_in, write_addr, wr_en and read_addr, and consumes its data_out.

Parameters:
- DATA_WIDTH, 128, BRAM word width
- ADDR_WIDTH, 6, BRAM address width (depth 2**ADDR_WIDTH)
- NUM_REQ, 4, number of requesters (>=2)

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- wr_req  input  NUM_REQ  per-requester write request, held until granted
- wr_addr  input  NUM_REQ*ADDR_WIDTH  flattened write addresses, requester i at slice i
- wr_data  input  NUM_REQ*DATA_WIDTH  flattened write data
- wr_gnt  output  NUM_REQ  one-hot write grant, same cycle
- rd_req  input  NUM_REQ  per-requester read request, held until granted
- rd_addr  input  NUM_REQ*ADDR_WIDTH  flattened read addresses
- rd_gnt  output  NUM_REQ  one-hot read grant, same cycle
- rd_valid  output  NUM_REQ  one-hot, read data valid for requester i
- rd_data  output  DATA_WIDTH  registered read data, shared by all requesters
- bram_wr_en  output  1  to BRAM wr_en
- bram_write_addr  output  ADDR_WIDTH  to BRAM write_addr
- bram_data_in  output  DATA_WIDTH  to BRAM data_in
- bram_read_addr  output  ADDR_WIDTH  to BRAM read_addr
- bram_data_out  input  DATA_WIDTH  from BRAM data_out (combinational read)

Behaviour:
- Reset (async, rst_n low): wr_ptr=0, rd_ptr=0, rd_valid=0, rd_data=0. While rst_n is low, wr_gnt, rd_gnt and bram_wr_en are forced to 0.
- Write arbitration (combinational): search wr_req starting at index wr_ptr and wrap modulo NUM_REQ; the first requester found gets wr_gnt. bram_wr_en = |wr_gnt. bram_write_addr and bram_data_in mux the granted slice, and are 0 when there is no grant.
- On a granted cycle, wr_ptr <= (winner+1) mod NUM_REQ at the clk edge. With no request, wr_ptr holds.
- Read arbitration: identical, using rd_ptr, rd_req and rd_gnt. bram_read_addr = granted slice, else 0.
- Read return: at the edge after a read grant, rd_data <= bram_data_out and rd_valid <= rd_gnt. Latency is exactly 1 cycle.
- With no read grant, rd_valid <= 0 and rd_data holds its last value.
- Handshake: a transfer occurs when req[i] && gnt[i] in the same cycle. A requester drops or changes its request only after its grant. Back-to-back grants to the same requester are allowed only if no other requester is pending.
- A single requester may hold both a write grant and a read grant in the same cycle.
- Same-address read and write in one cycle: the BRAM read is asynchronous and the write lands at the edge, so rd_data returns the OLD contents (see optional feature).
- Fairness: with all NUM_REQ requests held continuously, each requester is granted exactly once every NUM_REQ cycles.
- Reset mid-operation: any in-flight read return is discarded (rd_valid=0) and pointers return to 0. BRAM contents are not cleared.

Optional Feature:
- Macro: BRAM_ARB_WR_BYPASS_EN
- Defined: when bram_wr_en is high and bram_write_addr == bram_read_addr with a read granted in the same cycle, rd_data captures bram_data_in (write-first semantics).
- Undefined: rd_data always captures bram_data_out (read-first, old data).

Test Plan:
- Reset then single write: wr_req=4'b0001, addr 5, data 0xA5 -> wr_gnt=0001 same cycle, bram_wr_en=1. Next cycle rd_req=0001 at addr 5 -> rd_gnt=0001; one cycle later rd_valid=0001, rd_data=0xA5.
- All four wr_req held for 8 cycles -> wr_gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- rd_req=1010 from reset -> grants 0010 then 1000. rd_valid follows each grant by exactly 1 cycle with matching addresses.
- Addr 9 holds 0x11. Same cycle: write 0x22 to addr 9 and read addr 9 -> rd_data=0x11 without the macro, 0x22 with BRAM_ARB_WR_BYPASS_EN.
- Read granted, then rst_n pulsed low before the next edge -> rd_valid stays 0, grants drop immediately, pointers back to 0 (next all-request grant is 0001).
- Requester 2 sole requester for 3 cycles -> wr_gnt=0100 every cycle. Then requester 0 joins -> next grant goes to requester 0 (pointer at 3 wraps to 0).
